// File: rtl/pic_ack_sequencer_if.sv
// pic_ack_sequencer_if: CPU/controller-facing signal bundle of the 8259A acknowledge sequencer.
interface pic_ack_sequencer_if;
    logic [7:0] interruptVector;
    logic       intaN;
    logic [4:0] icw2Base;
    logic       aeoiEn;
    logic       eoiCmd;
    logic       eoiSpecific;
    logic [2:0] eoiLevel;
    logic       intOut;
    logic [7:0] ISR;
    logic [7:0] irrClear;
    logic [7:0] dataOut;
    logic       dataOutEn;
    modport master (
        output interruptVector, intaN, icw2Base, aeoiEn, eoiCmd, eoiSpecific, eoiLevel,
        input  intOut, ISR, irrClear, dataOut, dataOutEn
    );
    modport slave (
        input  interruptVector, intaN, icw2Base, aeoiEn, eoiCmd, eoiSpecific, eoiLevel,
        output intOut, ISR, irrClear, dataOut, dataOutEn
    );
endinterface

// File: rtl/pic_ack_sequencer.sv
// pic_ack_sequencer: INT raise, two-pulse 8086 INTA handshake and In-Service Register with EOI/AEOI.
module pic_ack_sequencer (
    input logic                 clk,
    input logic                 rst_n,
    pic_ack_sequencer_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, PEND, ACK1, WAIT2, ACK2} state_t;
    state_t     state, state_n;
    logic       inta_prev, int_q, int_n, den_q, den_n, spur_q, spur_n;
    logic [2:0] lvl_q, lvl_n, enc;
    logic [7:0] isr_q, isr_n, irr_q, irr_n, dout_q, dout_n, isr_set, aeoi_clr, eoi_clr;
    logic       fall, rise;
    assign fall = inta_prev & ~bus.intaN;
    assign rise = ~inta_prev & bus.intaN;
    assign bus.intOut    = int_q;
    assign bus.ISR       = isr_q;
    assign bus.irrClear  = irr_q;
    assign bus.dataOut   = dout_q;
    assign bus.dataOutEn = den_q;
    always_comb begin
        enc = 3'd0;
        for (int i = 0; i < 8; i++)
            if (bus.interruptVector[i]) enc = i[2:0];
    end
    // isolate lowest set bit for non-specific EOI
    assign eoi_clr = !bus.eoiCmd ? 8'h00 :
                     bus.eoiSpecific ? 8'b1 << bus.eoiLevel : isr_q & (~isr_q + 8'd1);
    always_comb begin
        state_n  = state;
        int_n    = int_q;
        den_n    = den_q;
        dout_n   = dout_q;
        lvl_n    = lvl_q;
        spur_n   = spur_q;
        irr_n    = 8'h00;
        isr_set  = 8'h00;
        aeoi_clr = 8'h00;
        case (state)
            IDLE: if (|bus.interruptVector) begin
                int_n   = 1'b1;
                state_n = PEND;
            end
            PEND: if (fall) begin
                int_n   = 1'b0;
                state_n = ACK1;
                spur_n  = ~|bus.interruptVector;
                lvl_n   = spur_n ? 3'd7 : enc;
                isr_set = spur_n ? 8'h00 : 8'b1 << enc;
                irr_n   = isr_set;
            end
            ACK1: if (rise) state_n = WAIT2;
            WAIT2: if (fall) begin
                dout_n  = {bus.icw2Base, lvl_q};
                den_n   = 1'b1;
                state_n = ACK2;
            end
            ACK2: if (rise) begin
                den_n    = 1'b0;
                aeoi_clr = (bus.aeoiEn && !spur_q) ? 8'b1 << lvl_q : 8'h00;
                state_n  = IDLE;
            end
            default: state_n = IDLE;
        endcase
        isr_n = (isr_q & ~eoi_clr & ~aeoi_clr) | isr_set;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            inta_prev <= 1'b1;
            int_q     <= 1'b0;
            den_q     <= 1'b0;
            spur_q    <= 1'b0;
            lvl_q     <= 3'd0;
            isr_q     <= 8'h00;
            irr_q     <= 8'h00;
            dout_q    <= 8'h00;
        end else begin
            state     <= state_n;
            inta_prev <= bus.intaN;
            int_q     <= int_n;
            den_q     <= den_n;
            spur_q    <= spur_n;
            lvl_q     <= lvl_n;
            isr_q     <= isr_n;
            irr_q     <= irr_n;
            dout_q    <= dout_n;
        end
    end
endmodule

// File: doc/pic_ack_sequencer.md
# pic_ack_sequencer

Interrupt-acknowledge sequencer for the 8259A PIC; the CPU-facing counterpart to the priority resolver. It takes the one-hot resolved request and raises INT to the CPU. It then runs the two-pulse 8086 INTA handshake: on the first pulse it sets the ISR bit and clears the IRR bit, and on the second it drives the vector byte. It also owns the In-Service Register, including normal, specific and automatic EOI.

## Interface
Parameters:
- none; fixed 8 interrupt levels, 8086 two-pulse INTA mode only

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- interruptVector  in  8  one-hot highest-priority unmasked request from resolver; 0 = none
- intaN  in  1  CPU acknowledge strobe, active-low, already synchronised to clk
- icw2Base  in  5  vector base T7..T3 from ICW2
- aeoiEn  in  1  automatic EOI mode (ICW4 AEOI)
- eoiCmd  in  1  one-cycle EOI strobe from OCW2 decode
- eoiSpecific  in  1  qualifies eoiCmd: 1 = specific, 0 = non-specific
- eoiLevel  in  3  level cleared by specific EOI
- intOut  out  1  INT to CPU, active-high
- ISR  out  8  In-Service Register, fed back to resolver
- irrClear  out  8  one-cycle one-hot pulse clearing the acknowledged IRR bit
- dataOut  out  8  vector byte {icw2Base, level}
- dataOutEn  out  1  data-bus drive enable

## Operation
- Reset (rst_n low at a clk edge): state IDLE; intOut=0, ISR=0, irrClear=0, dataOut=0, dataOutEn=0; intaPrev=1; latched level=0.
- Falling-edge detect: `fall = intaPrev & ~intaN`. Rising-edge detect: `rise = ~intaPrev & intaN`. intaPrev is a register.
- State IDLE: interruptVector≠0 → intOut=1, go to PEND. Falls in IDLE are ignored.
- State PEND: intOut stays 1 even if interruptVector drops to 0. On fall:
  - Latch level = index of the set bit of interruptVector, then set ISR[level] and pulse irrClear[level].
  - If interruptVector=0 at fall, latch level 7 as spurious: no ISR set, no irrClear.
  - Either way: intOut=0, go to ACK1.
- State ACK1: rise → WAIT2.
- State WAIT2: fall → dataOut={icw2Base, level}, dataOutEn=1, go to ACK2.
- State ACK2: rise →
  - dataOutEn=0.
  - If aeoiEn and not spurious, clear ISR[level].
  - Go to IDLE.
- dataOut holds its last value when dataOutEn=0.
- A new request is evaluated only in IDLE. It may re-raise intOut the cycle after returning to IDLE.
- Non-specific EOI (eoiCmd & ~eoiSpecific): clear the lowest-index set bit of ISR; no effect if ISR=0.
- Specific EOI (eoiCmd & eoiSpecific): clear ISR[eoiLevel]; no effect if already clear.
- EOI is accepted in any state.
- Same-cycle EOI clear and ISR set:
  - Different bits: both apply.
  - Same bit: the set wins.
- Same-cycle EOI clear and AEOI clear: both apply.
- rst_n low in any state aborts the sequence: dataOutEn drops at that edge, ISR is cleared.

## Timing
- Edge k means the clk edge at which a condition is first sampled.
- intOut rises after edge k, where k is the first edge sampling interruptVector≠0 in IDLE (1-cycle latency).
- First INTA: ISR set, irrClear pulse and intOut=0 are visible after edge k, where k is the first edge sampling intaN=0. irrClear lasts exactly one cycle.
- Second INTA: dataOut/dataOutEn are valid after edge k, where k is the first edge sampling the second intaN=0. They stay valid while intaN is low. They deassert after the first edge sampling intaN=1.
- AEOI clear is visible after the same edge that drops dataOutEn.
- EOI clear is visible after the edge sampling eoiCmd=1.
- Minimum INTA low and high widths are 1 clk each. Shorter glitches are not detected.

## Test plan
- **Normal acknowledge.** Reset, icw2Base=5'b00001, interruptVector=8'h08, then two INTA pulses of 3 clk each → all of:
  - intOut=1 one cycle after the request.
  - irrClear=8'h08 for one cycle and ISR=8'h08 after the first fall.
  - dataOut=8'h0B with dataOutEn=1 during the second low.
  - ISR stays 8'h08 (aeoiEn=0).
- **AEOI.** Same as the normal acknowledge with aeoiEn=1 → ISR returns to 8'h00 on the edge where the second intaN rise drops dataOutEn.
- **Spurious.** interruptVector=8'h04 then 0 before the first INTA → dataOut=8'h0F; ISR=0; irrClear never pulses.
- **EOI variants.** With ISR=8'h28:
  - Non-specific EOI → ISR=8'h20.
  - Specific EOI with eoiLevel=5 → ISR=8'h00.
  - Specific EOI with eoiLevel=2 on ISR=0 → no change.
- **Simultaneous events.** First-INTA fall latching level 3 coincides with a non-specific EOI while ISR=8'h01 → ISR=8'h08.
- **Reset mid-handshake.** rst_n low during the second INTA low → next cycle dataOutEn=0, ISR=0, intOut=0, state IDLE. A held request re-raises intOut one cycle after rst_n returns high.
